// File: rtl/fm_wm_comb_controller.sv
// Combination-stage (FM x WM) sequencer and MAC for the GCN accelerator.
// Streams one feature-matrix row against every weight-matrix column, builds
// the full output row, and hands it downstream on a valid/ready port.
module fm_wm_comb_controller #(
  parameter int FEATURE_ROWS = 6,
  parameter int FEATURE_COLS = 96,
  parameter int WEIGHT_COLS  = 3,
  parameter int FM_WIDTH     = 5,
  parameter int WM_WIDTH     = 5,
  parameter int DOT_WIDTH    = 16,
  parameter int ROW_BW       = $clog2(FEATURE_ROWS),
  parameter int K_BW         = $clog2(FEATURE_COLS),
  parameter int C_BW         = $clog2(WEIGHT_COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             fm_read_en,
  output logic [ROW_BW-1:0]                fm_row_addr,
  output logic [K_BW-1:0]                  fm_col_addr,
  input  logic [FM_WIDTH-1:0]              fm_read_data,
  output logic                             wm_read_en,
  output logic [K_BW-1:0]                  wm_row_addr,
  output logic [C_BW-1:0]                  wm_col_addr,
  input  logic [WM_WIDTH-1:0]              wm_read_data,
  output logic                             comb_valid,
  input  logic                             comb_ready,
  output logic [WEIGHT_COLS*DOT_WIDTH-1:0] comb_data,
  output logic                             enable_comb_row_counter,
  output logic                             busy,
  output logic                             done
);

  localparam int PROD_W = FM_WIDTH + WM_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ROW_BW-1:0] R_LAST = ROW_BW'(FEATURE_ROWS - 1);
  localparam logic [K_BW-1:0]   K_LAST = K_BW'(FEATURE_COLS - 1);
  localparam logic [C_BW-1:0]   C_LAST = C_BW'(WEIGHT_COLS - 1);

  logic [2:0]           state;
  logic [ROW_BW-1:0]    r;
  logic [K_BW-1:0]      k;
  logic [C_BW-1:0]      c;
  logic [DOT_WIDTH-1:0] acc;
  logic [PROD_W-1:0]    prod;
  logic [DOT_WIDTH-1:0] sum;

  // Product of the data returned for last cycle's read; the sum wraps modulo 2^DOT_WIDTH.
  assign prod = PROD_W'(fm_read_data) * PROD_W'(wm_read_data);
  assign sum  = acc + DOT_WIDTH'(prod);

  // Strobes, addresses and status are pure decodes of the state and counters.
  assign fm_read_en              = (state == S_MAC);
  assign wm_read_en              = (state == S_MAC);
  assign fm_row_addr             = r;
  assign fm_col_addr             = k;
  assign wm_row_addr             = k;
  assign wm_col_addr             = c;
  assign comb_valid              = (state == S_OUT);
  assign enable_comb_row_counter = comb_valid & comb_ready;
  assign busy                    = (state != S_IDLE);
  assign done                    = (state == S_DONE);

  // Sequencer, accumulator and output row register.
  // NOTE: every register here uses non-blocking assignment so all updates
  // see the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      r         <= '0;
      k         <= '0;
      c         <= '0;
      acc       <= '0;
      comb_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            r     <= '0;
            c     <= '0;
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          // At k=0 the returning data is stale, so clearing here makes the
          // first real product load straight into the accumulator.
          acc <= (k == '0) ? '0 : sum;
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: begin
          comb_data[c*DOT_WIDTH +: DOT_WIDTH] <= sum;
          if (c == C_LAST) begin
            c     <= '0;
            state <= S_OUT;
          end else begin
            c     <= c + 1'b1;
            state <= S_MAC;
          end
        end
        S_OUT: begin
          if (comb_ready) begin
            if (r == R_LAST) begin
              r     <= '0;
              state <= S_DONE;
            end else begin
              r     <= r + 1'b1;
              state <= S_MAC;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
